// File: rtl/lsu_seq_ctrl_if.sv
// Request, response and data-memory port bundle of the sequential load/store unit.
// master: the LSU itself; slave: the MEM stage plus data memory facing it.
interface lsu_seq_ctrl_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned B = XLEN / 8;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        sl_type;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   store_data;
  logic              resp_valid;
  logic              resp_err;
  logic [XLEN-1:0]   load_data;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [B-1:0]      mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    input  req_valid, sl_type, addr, store_data, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_err, load_data,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );

  modport slave (
    output req_valid, sl_type, addr, store_data, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_err, load_data,
           mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
  );
endinterface

// File: rtl/lsu_seq_ctrl.sv
// Sequential load/store unit: one access per handshake, req/gnt/rvalid memory port.
// Define MISALIGN_SPLIT_EN to run beat-crossing accesses as two beats instead of erroring.
module lsu_seq_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_seq_ctrl_if.master bus
);
  localparam int unsigned B     = XLEN / 8;
  localparam int unsigned OFF_W = $clog2(B);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] BEAT0 = 3'd1;
  localparam logic [2:0] WAIT0 = 3'd2;
  localparam logic [2:0] BEAT1 = 3'd3;
  localparam logic [2:0] WAIT1 = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  logic [2:0]        state;
  logic              is_store_q;
  logic              is_unsigned_q;
  logic [3:0]        n_q;
  logic [OFF_W-1:0]  off_q;
  logic              resp_err_q;
  logic [XLEN-1:0]   load_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [B-1:0]      mem_wstrb_q;
  logic [XLEN-1:0]   mem_wdata_q;

  function automatic logic [B-1:0] byte_mask(input logic [3:0] n);
    logic [B-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < B; i++)
      if (i < 32'(n)) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [XLEN-1:0] bit_mask(input logic [B-1:0] bm);
    logic [XLEN-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < B; i++)
      m[8*i +: 8] = {8{bm[i]}};
    return m;
  endfunction

  // Shift the two-beat window down to the access offset, keep n bytes, extend.
  function automatic logic [XLEN-1:0] extract(input logic [2*XLEN-1:0] raw,
                                              input logic [OFF_W-1:0]  off,
                                              input logic [3:0]        n,
                                              input logic              uns);
    logic [2*XLEN-1:0] sh;
    logic [XLEN-1:0]   m;
    logic              sgn;
    sh = raw >> {off, 3'b000};
    m  = bit_mask(byte_mask(n));
    case (n)
      4'd1:    sgn = sh[7];
      4'd2:    sgn = sh[15];
      4'd4:    sgn = sh[31];
      default: sgn = sh[XLEN-1];
    endcase
    return (sh[XLEN-1:0] & m) | ((!uns && sgn) ? ~m : '0);
  endfunction

  logic [3:0]       n_in;
  logic [OFF_W-1:0] off_in;
  logic [B-1:0]     bmask_in;
  logic             illegal_in;
  logic             cross_in;
  logic [XLEN-1:0]  lo_d;
  logic [B-1:0]     lo_s;

  always_comb begin
    case (bus.sl_type[1:0])
      2'b01:   n_in = 4'd1;
      2'b10:   n_in = 4'd2;
      2'b11:   n_in = 4'd4;
      default: n_in = 4'd8;
    endcase
    illegal_in = (bus.sl_type[1:0] == 2'b00) && (XLEN == 32);
    off_in     = bus.addr[OFF_W-1:0];
    bmask_in   = byte_mask(n_in);
    cross_in   = (32'(off_in) + 32'(n_in)) > B;
  end

`ifdef MISALIGN_SPLIT_EN
  logic [2*XLEN-1:0] wide_d;
  logic [2*B-1:0]    wide_s;
  logic [XLEN-1:0]   hi_d;
  logic [B-1:0]      hi_s;
  logic              split_q;
  logic [XLEN-1:0]   hi_d_q;
  logic [B-1:0]      hi_s_q;
  logic [XLEN-1:0]   rdata0_q;

  always_comb begin
    wide_d = {{XLEN{1'b0}}, bus.store_data & bit_mask(bmask_in)} << {off_in, 3'b000};
    wide_s = {{B{1'b0}}, bmask_in} << off_in;
    lo_d   = wide_d[XLEN-1:0];
    hi_d   = wide_d[2*XLEN-1:XLEN];
    lo_s   = wide_s[B-1:0];
    hi_s   = wide_s[2*B-1:B];
  end
`else
  always_comb begin
    lo_d = (bus.store_data & bit_mask(bmask_in)) << {off_in, 3'b000};
    lo_s = bmask_in << off_in;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      is_store_q    <= 1'b0;
      is_unsigned_q <= 1'b0;
      n_q           <= '0;
      off_q         <= '0;
      resp_err_q    <= 1'b0;
      load_q        <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wstrb_q   <= '0;
      mem_wdata_q   <= '0;
`ifdef MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      hi_d_q        <= '0;
      hi_s_q        <= '0;
      rdata0_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            is_store_q    <= bus.sl_type[3];
            is_unsigned_q <= bus.sl_type[2];
            n_q           <= n_in;
            off_q         <= off_in;
            resp_err_q    <= 1'b0;
            if (illegal_in) begin
              resp_err_q <= 1'b1;
              if (!bus.sl_type[3]) load_q <= '0;
              state <= DONE;
`ifndef MISALIGN_SPLIT_EN
            end else if (cross_in) begin
              resp_err_q <= 1'b1;
              state      <= DONE;
`endif
            end else begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.sl_type[3];
              mem_addr_q  <= {bus.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wstrb_q <= bus.sl_type[3] ? lo_s : '0;
              mem_wdata_q <= bus.sl_type[3] ? lo_d : '0;
`ifdef MISALIGN_SPLIT_EN
              split_q     <= cross_in;
              hi_s_q      <= bus.sl_type[3] ? hi_s : '0;
              hi_d_q      <= bus.sl_type[3] ? hi_d : '0;
`endif
              state       <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state     <= WAIT0;
          end
        end
        WAIT0: begin
          if (bus.mem_rvalid) begin
`ifdef MISALIGN_SPLIT_EN
            if (split_q) begin
              rdata0_q    <= bus.mem_rdata;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= mem_addr_q + ADDR_W'(B);
              mem_wstrb_q <= hi_s_q;
              mem_wdata_q <= hi_d_q;
              state       <= BEAT1;
            end else begin
              if (!is_store_q)
                load_q <= extract({{XLEN{1'b0}}, bus.mem_rdata}, off_q, n_q, is_unsigned_q);
              state <= DONE;
            end
`else
            if (!is_store_q)
              load_q <= extract({{XLEN{1'b0}}, bus.mem_rdata}, off_q, n_q, is_unsigned_q);
            state <= DONE;
`endif
          end
        end
`ifdef MISALIGN_SPLIT_EN
        BEAT1: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state     <= WAIT1;
          end
        end
        WAIT1: begin
          if (bus.mem_rvalid) begin
            if (!is_store_q)
              load_q <= extract({bus.mem_rdata, rdata0_q}, off_q, n_q, is_unsigned_q);
            state <= DONE;
          end
        end
`endif
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_err   = resp_err_q;
  assign bus.load_data  = load_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wstrb  = mem_wstrb_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_lsu_seq_ctrl.sv
// Scoreboard bench for lsu_seq_ctrl: XLEN=32 and XLEN=64 instances, grant-same-cycle memory.
module tb_lsu_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_seq_ctrl_if #(.XLEN(32), .ADDR_W(32)) b32 ();
  lsu_seq_ctrl_if #(.XLEN(64), .ADDR_W(32)) b64 ();

  lsu_seq_ctrl #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
  lsu_seq_ctrl #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(b64));

  assign b32.mem_gnt = b32.mem_req;
  assign b64.mem_gnt = b64.mem_req;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [63:0] data;
    int unsigned at;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  strb;
    logic [63:0] wdata;
  } beat_t;

  rsp_t        rq32[$], rq64[$];
  beat_t       bq32[$], bq64[$];
  logic [31:0] rd32[$];
  logic [63:0] rd64[$];
  rsp_t        er32, er64;
  beat_t       eb32, eb64;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: read data / write ack one cycle after the grant.
  always @(posedge clk) begin
    if (!rst_n) b32.mem_rvalid <= 1'b0;
    else if (b32.mem_req && b32.mem_gnt) begin
      b32.mem_rvalid <= 1'b1;
      if (!b32.mem_we && rd32.size() > 0) b32.mem_rdata <= rd32.pop_front();
      else b32.mem_rdata <= '0;
    end else b32.mem_rvalid <= 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) b64.mem_rvalid <= 1'b0;
    else if (b64.mem_req && b64.mem_gnt) begin
      b64.mem_rvalid <= 1'b1;
      if (!b64.mem_we && rd64.size() > 0) b64.mem_rdata <= rd64.pop_front();
      else b64.mem_rdata <= '0;
    end else b64.mem_rvalid <= 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b32.resp_valid) begin
        if (rq32.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp32_unexpected: got resp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          er32 = rq32.pop_front();
          chk("rsp32_cycle", 64'(cyc), 64'(er32.at));
          chk("rsp32_err", 64'(b32.resp_err), 64'(er32.err));
          chk("rsp32_load_data", 64'(b32.load_data), er32.data);
        end
      end
      if (b32.mem_req) begin
        if (bq32.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL beat32_unexpected: got mem_req addr %h expected none", b32.mem_addr);
        end else begin
          eb32 = bq32.pop_front();
          chk("beat32_we", 64'(b32.mem_we), 64'(eb32.we));
          chk("beat32_addr", 64'(b32.mem_addr), 64'(eb32.addr));
          chk("beat32_wstrb", 64'(b32.mem_wstrb), 64'(eb32.strb));
          if (eb32.we) chk("beat32_wdata", 64'(b32.mem_wdata), eb32.wdata);
        end
      end
      if (b64.resp_valid) begin
        if (rq64.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rsp64_unexpected: got resp_valid=1 expected none (cycle %0d)", cyc);
        end else begin
          er64 = rq64.pop_front();
          chk("rsp64_cycle", 64'(cyc), 64'(er64.at));
          chk("rsp64_err", 64'(b64.resp_err), 64'(er64.err));
          chk("rsp64_load_data", b64.load_data, er64.data);
        end
      end
      if (b64.mem_req) begin
        if (bq64.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL beat64_unexpected: got mem_req addr %h expected none", b64.mem_addr);
        end else begin
          eb64 = bq64.pop_front();
          chk("beat64_we", 64'(b64.mem_we), 64'(eb64.we));
          chk("beat64_addr", 64'(b64.mem_addr), 64'(eb64.addr));
          chk("beat64_wstrb", 64'(b64.mem_wstrb), 64'(eb64.strb));
          if (eb64.we) chk("beat64_wdata", b64.mem_wdata, eb64.wdata);
        end
      end
    end
  end

  task automatic wait_idle();
    int unsigned k;
    k = 0;
    while ((rq32.size() != 0 || bq32.size() != 0 || rq64.size() != 0 || bq64.size() != 0)
           && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (rq32.size() != 0 || bq32.size() != 0 || rq64.size() != 0 || bq64.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL timeout: got %0d/%0d/%0d/%0d pending expected 0",
               rq32.size(), bq32.size(), rq64.size(), bq64.size());
      rq32.delete(); bq32.delete(); rq64.delete(); bq64.delete();
    end
  endtask

  // lat counts cycles from the handshake cycle to the resp_valid cycle.
  task automatic issue32(input logic [3:0] t, input logic [31:0] a, input logic [31:0] sd,
                         input int unsigned lat, input logic err, input logic [31:0] ld);
    @(negedge clk);
    chk("ready32", 64'(b32.req_ready), 64'd1);
    b32.req_valid = 1'b1; b32.sl_type = t; b32.addr = a; b32.store_data = sd;
    rq32.push_back('{err: err, data: 64'(ld), at: cyc + lat});
    @(posedge clk);
    #1 b32.req_valid = 1'b0;
    wait_idle();
  endtask

  task automatic issue64(input logic [3:0] t, input logic [31:0] a, input logic [63:0] sd,
                         input int unsigned lat, input logic err, input logic [63:0] ld);
    @(negedge clk);
    chk("ready64", 64'(b64.req_ready), 64'd1);
    b64.req_valid = 1'b1; b64.sl_type = t; b64.addr = a; b64.store_data = sd;
    rq64.push_back('{err: err, data: ld, at: cyc + lat});
    @(posedge clk);
    #1 b64.req_valid = 1'b0;
    wait_idle();
  endtask

  logic [31:0] ld32;

  initial begin
    b32.req_valid = 1'b0; b32.sl_type = '0; b32.addr = '0; b32.store_data = '0;
    b64.req_valid = 1'b0; b64.sl_type = '0; b64.addr = '0; b64.store_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready32", 64'(b32.req_ready), 64'd1);
    chk("rst_resp_valid32", 64'(b32.resp_valid), 64'd0);
    chk("rst_resp_err32", 64'(b32.resp_err), 64'd0);
    chk("rst_mem_req32", 64'(b32.mem_req), 64'd0);
    chk("rst_mem_addr32", 64'(b32.mem_addr), 64'd0);
    chk("rst_load_data32", 64'(b32.load_data), 64'd0);
    chk("rst_ready64", 64'(b64.req_ready), 64'd1);
    chk("rst_mem_wstrb64", 64'(b64.mem_wstrb), 64'd0);
    rst_n = 1'b1;

    bq32.push_back('{we: 1'b0, addr: 32'h100, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'hDEADBEEF);
    issue32(4'b0011, 32'h100, 32'h0, 3, 1'b0, 32'hDEADBEEF);

    bq32.push_back('{we: 1'b0, addr: 32'h100, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'h80112233);
    issue32(4'b0001, 32'h103, 32'h0, 3, 1'b0, 32'hFFFFFF80);

    bq32.push_back('{we: 1'b0, addr: 32'h100, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'h80112233);
    issue32(4'b0101, 32'h103, 32'h0, 3, 1'b0, 32'h00000080);
    ld32 = 32'h00000080;

    bq32.push_back('{we: 1'b1, addr: 32'h100, strb: 8'b1100, wdata: 64'hABCD0000});
    issue32(4'b1010, 32'h102, 32'h1234ABCD, 3, 1'b0, ld32);

    bq32.push_back('{we: 1'b0, addr: 32'h100, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'hF00D1234);
    issue32(4'b0010, 32'h102, 32'h0, 3, 1'b0, 32'hFFFFF00D);

    bq32.push_back('{we: 1'b0, addr: 32'h100, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'h55559ABC);
    issue32(4'b0110, 32'h100, 32'h0, 3, 1'b0, 32'h00009ABC);
    ld32 = 32'h00009ABC;

    bq32.push_back('{we: 1'b1, addr: 32'h100, strb: 8'b0010, wdata: 64'h0000EE00});
    issue32(4'b1001, 32'h101, 32'h123456EE, 3, 1'b0, ld32);

`ifdef MISALIGN_SPLIT_EN
    bq32.push_back('{we: 1'b1, addr: 32'h100, strb: 8'b1000, wdata: 64'hDD000000});
    bq32.push_back('{we: 1'b1, addr: 32'h104, strb: 8'b0111, wdata: 64'h00AABBCC});
    issue32(4'b1011, 32'h103, 32'hAABBCCDD, 5, 1'b0, ld32);

    bq32.push_back('{we: 1'b0, addr: 32'h100, strb: 8'h0, wdata: 64'h0});
    bq32.push_back('{we: 1'b0, addr: 32'h104, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'h44332211);
    rd32.push_back(32'h88776655);
    issue32(4'b0011, 32'h102, 32'h0, 5, 1'b0, 32'h66554433);

    bq32.push_back('{we: 1'b0, addr: 32'hFFFFFFFC, strb: 8'h0, wdata: 64'h0});
    bq32.push_back('{we: 1'b0, addr: 32'h00000000, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'hAB000000);
    rd32.push_back(32'h000000CD);
    issue32(4'b0010, 32'hFFFFFFFF, 32'h0, 5, 1'b0, 32'hFFFFCDAB);
`else
    issue32(4'b1011, 32'h103, 32'hAABBCCDD, 1, 1'b1, ld32);
    issue32(4'b0011, 32'h102, 32'h0, 1, 1'b1, ld32);
    issue32(4'b0010, 32'hFFFFFFFF, 32'h0, 1, 1'b1, ld32);
`endif

    issue32(4'b0000, 32'h200, 32'h0, 1, 1'b1, 32'h0);

    bq32.push_back('{we: 1'b0, addr: 32'h104, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'h13579BDF);
    issue32(4'b0011, 32'h104, 32'h0, 3, 1'b0, 32'h13579BDF);

    // Abort a load while it waits for read data.
    bq32.push_back('{we: 1'b0, addr: 32'h100, strb: 8'h0, wdata: 64'h0});
    rd32.push_back(32'h11111111);
    @(negedge clk);
    b32.req_valid = 1'b1; b32.sl_type = 4'b0011; b32.addr = 32'h100;
    @(posedge clk);
    #1 b32.req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", 64'(b32.mem_req), 64'd0);
    chk("abort_ready", 64'(b32.req_ready), 64'd1);
    chk("abort_resp_valid", 64'(b32.resp_valid), 64'd0);
    chk("abort_load_data", 64'(b32.load_data), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_ready_after", 64'(b32.req_ready), 64'd1);
    chk("abort_beats_left", 64'(bq32.size()), 64'd0);

    bq64.push_back('{we: 1'b0, addr: 32'h8, strb: 8'h0, wdata: 64'h0});
    rd64.push_back(64'h0123456789ABCDEF);
    issue64(4'b0000, 32'h8, 64'h0, 3, 1'b0, 64'h0123456789ABCDEF);

    bq64.push_back('{we: 1'b0, addr: 32'h8, strb: 8'h0, wdata: 64'h0});
    rd64.push_back(64'h80000000_12345678);
    issue64(4'b0011, 32'hC, 64'h0, 3, 1'b0, 64'hFFFFFFFF_80000000);

    bq64.push_back('{we: 1'b0, addr: 32'h8, strb: 8'h0, wdata: 64'h0});
    rd64.push_back(64'h80000000_12345678);
    issue64(4'b0111, 32'hC, 64'h0, 3, 1'b0, 64'h00000000_80000000);

    bq64.push_back('{we: 1'b1, addr: 32'h10, strb: 8'hFF, wdata: 64'h1122334455667788});
    issue64(4'b1000, 32'h10, 64'h1122334455667788, 3, 1'b0, 64'h00000000_80000000);

    bq64.push_back('{we: 1'b1, addr: 32'h10, strb: 8'hC0, wdata: 64'hBEEF000000000000});
    issue64(4'b1010, 32'h16, 64'h777777777777BEEF, 3, 1'b0, 64'h00000000_80000000);

    repeat (4) @(negedge clk);
    chk("end_rsp32_pending", 64'(rq32.size()), 64'd0);
    chk("end_rsp64_pending", 64'(rq64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
